player_move_ctrl: RTL and testbench
===================================

# player_move_ctrl

Player movement controller for the maze game. It sits directly upstream of the game-state FSM. It accepts one-cycle direction pulses from the key decoder while the game is in the map state, looks up the target cell in the maze wall ROM, and commits legal moves to the player position. It raises `arrived` when the player reaches the exit cell; the FSM consumes `arrived` to enter the win state.

## Interface
- `X_W`, 4: x coordinate width; maze is 2^X_W columns wide.
- `Y_W`, 4: y coordinate width; maze is 2^Y_W rows tall.
- `START_X`, 0: player x after reset or on return to welcome.
- `START_Y`, 0: player y after reset or on return to welcome.
- `EXIT_X`, 15: exit cell x.
- `EXIT_Y`, 15: exit cell y.
- `STEP_W`, 10: width of the step counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_sys_n`  in  1  asynchronous, active-low reset.
- `state`  in  2  game state from the FSM: 00 welcome, 01 map, 10 win.
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each  one-cycle move request pulses. Up is y-1, down is y+1, left is x-1, right is x+1.
- `rom_addr`  out  X_W+Y_W  registered wall-ROM address, {y, x}.
- `rom_wall`  in  1  wall bit of the addressed cell (1 = wall). Valid one cycle after `rom_addr` changes (synchronous ROM).
- `player_x`  out  X_W  current x.
- `player_y`  out  Y_W  current y.
- `arrived`  out  1  player is on the exit cell; sticky.
- `blocked`  out  1  one-cycle pulse when a move is rejected.
- `busy`  out  1  a lookup is in flight.
- `steps`  out  STEP_W  count of committed moves; saturates.

## Operation
- Reset values: `player_x`=START_X, `player_y`=START_Y, `rom_addr`=0, `arrived`=0, `blocked`=0, `busy`=0, `steps`=0. The controller FSM resets to IDLE.
- Controller states are IDLE, WAIT and DECIDE.
- **IDLE**
  - Acts only when `state`==01 and exactly one `mv_*` is high.
  - It computes the target cell (tx, ty).
  - If the target is outside the maze (x-1 at 0, x+1 at max, and likewise for y): pulse `blocked`, stay in IDLE, make no ROM access.
  - Otherwise: register `rom_addr`={ty,tx}, latch tx/ty, go to WAIT, set `busy`.
- **WAIT**: unconditionally go to DECIDE, because ROM data is not yet valid.
- **DECIDE**
  - Sample `rom_wall`.
  - If it is 0: `player_x/y` <= tx/ty and `steps` <= `steps`+1, saturating at all-ones.
  - If it is 1: pulse `blocked` and leave the position unchanged.
  - In both cases return to IDLE and clear `busy`.
- Zero or two or more simultaneous `mv_*` pulses are ignored: no `blocked` pulse, no ROM access.
- Move pulses arriving while `busy` is high are dropped and never queued.
- `arrived` is set in the same clock edge that commits a position equal to (EXIT_X, EXIT_Y). It stays set while `state` is 01 or 10.
- In the win state (10), new moves are ignored. A lookup already in flight completes normally.
- When `state`==00 (welcome), each cycle:
  - force IDLE and abort any lookup;
  - set position to start, clear `steps`, `arrived`, `blocked` and `busy`.
- `state`==11 is treated as welcome.
- Assertion of `rst_sys_n` at any point, including during WAIT or DECIDE, immediately restores all reset values.

## Timing
- Move pulse accepted in cycle N:
  - `rom_addr` valid at N+1;
  - `rom_wall` sampled at N+2;
  - `player_x/y`, `steps`, `arrived` and `blocked` update visible at N+3.
- Bounds rejection: `blocked` is high in cycle N+1 only, and `busy` never asserts.
- `busy` is high in cycles N+1 and N+2. The earliest next accepted pulse is in cycle N+3.
- The FSM sees `arrived` in cycle N+3 and registers win at N+4.
- `blocked` is exactly one cycle wide.
- All outputs are registered.

## Test plan
- Reset and free cell: reset, `state`=01, all ROM cells 0, pulse `mv_right` at cycle 10. Required: `rom_addr`=0x01 at cycle 11; `player_x`=1, `player_y`=0 and `steps`=1 at cycle 13; `blocked` never asserts.
- Wall: cell (0,1) has `rom_wall`=1, pulse `mv_down` from (0,0). Required: `blocked` high for exactly one cycle at N+3; position stays (0,0); `steps` stays 0.
- Bounds and multi-key:
  - `mv_left` at (0,0): `blocked` at N+1, `busy` stays 0.
  - `mv_up` and `mv_right` pulsed in the same cycle: no response at all.
- Busy drop and exit: pulse `mv_right` at cycle N and again at N+1 from (14,15) with an open ROM. Required: only one move commits; `player_x`=15; `arrived`=1 at N+3; `steps` increments by exactly 1.
- Abort and reset:
  - Drive `state`=00 during WAIT: next cycle shows IDLE, position (START_X, START_Y), `busy`=0, and no commit afterwards.
  - Separately, pull `rst_sys_n` low mid-DECIDE: all outputs return to reset values asynchronously.
- Saturation: with `STEP_W`=2, commit five legal moves. Required: `steps` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/player_move_ctrl.sv
// Player movement controller: validates one-cycle move requests against maze bounds and the
// synchronous wall ROM, then commits legal moves, counts steps and flags arrival at the exit.
module player_move_ctrl #(
    parameter int X_W     = 4,
    parameter int Y_W     = 4,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int EXIT_X  = 15,
    parameter int EXIT_Y  = 15,
    parameter int STEP_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_sys_n,
    input  logic [1:0]           state,
    input  logic                 mv_up,
    input  logic                 mv_down,
    input  logic                 mv_left,
    input  logic                 mv_right,
    output logic [X_W+Y_W-1:0]   rom_addr,
    input  logic                 rom_wall,
    output logic [X_W-1:0]       player_x,
    output logic [Y_W-1:0]       player_y,
    output logic                 arrived,
    output logic                 blocked,
    output logic                 busy,
    output logic [STEP_W-1:0]    steps
);

    // state  | meaning
    // IDLE   | waiting for a single move request in the map state
    // WAIT   | ROM address registered, data not yet valid
    // DECIDE | rom_wall valid: commit the move or reject it
    typedef enum logic [1:0] {IDLE, WAIT, DECIDE} ctrl_t;

    localparam logic [X_W-1:0]    X_MAX   = {X_W{1'b1}};
    localparam logic [Y_W-1:0]    Y_MAX   = {Y_W{1'b1}};
    localparam logic [X_W-1:0]    X_START = X_W'(START_X);
    localparam logic [Y_W-1:0]    Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0]    X_EXIT  = X_W'(EXIT_X);
    localparam logic [Y_W-1:0]    Y_EXIT  = Y_W'(EXIT_Y);
    localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

    ctrl_t                ctrl_q, ctrl_d;
    logic [X_W-1:0]       x_q, x_d, tx_q, tx_d;
    logic [Y_W-1:0]       y_q, y_d, ty_q, ty_d;
    logic [X_W+Y_W-1:0]   addr_q, addr_d;
    logic                 arrived_q, arrived_d;
    logic                 blocked_q, blocked_d;
    logic                 busy_q, busy_d;
    logic [STEP_W-1:0]    steps_q, steps_d;

    logic [3:0]           mv_vec;
    logic                 one_hot;
    logic                 in_map;
    logic                 in_welcome;
    logic                 oob;
    logic [X_W-1:0]       tgt_x;
    logic [Y_W-1:0]       tgt_y;

    always_comb begin
        mv_vec     = {mv_up, mv_down, mv_left, mv_right};
        one_hot    = (mv_vec != 4'd0) && ((mv_vec & (mv_vec - 4'd1)) == 4'd0);
        in_map     = (state == 2'b01);
        in_welcome = (state[1] == state[0]);

        tgt_x = x_q;
        tgt_y = y_q;
        oob   = 1'b0;
        if (mv_up) begin
            oob   = (y_q == '0);
            tgt_y = y_q - Y_W'(1);
        end else if (mv_down) begin
            oob   = (y_q == Y_MAX);
            tgt_y = y_q + Y_W'(1);
        end else if (mv_left) begin
            oob   = (x_q == '0);
            tgt_x = x_q - X_W'(1);
        end else if (mv_right) begin
            oob   = (x_q == X_MAX);
            tgt_x = x_q + X_W'(1);
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        x_d       = x_q;
        y_d       = y_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        addr_d    = addr_q;
        arrived_d = arrived_q;
        blocked_d = 1'b0;
        busy_d    = busy_q;
        steps_d   = steps_q;

        case (ctrl_q)
            IDLE: begin
                if (in_map && one_hot) begin
                    if (oob) begin
                        blocked_d = 1'b1;
                    end else begin
                        addr_d = {tgt_y, tgt_x};
                        tx_d   = tgt_x;
                        ty_d   = tgt_y;
                        busy_d = 1'b1;
                        ctrl_d = WAIT;
                    end
                end
            end
            WAIT: ctrl_d = DECIDE;
            DECIDE: begin
                if (!rom_wall) begin
                    x_d     = tx_q;
                    y_d     = ty_q;
                    steps_d = (steps_q == STEP_MAX) ? steps_q : steps_q + STEP_W'(1);
                    if (tx_q == X_EXIT && ty_q == Y_EXIT) begin
                        arrived_d = 1'b1;
                    end
                end else begin
                    blocked_d = 1'b1;
                end
                busy_d = 1'b0;
                ctrl_d = IDLE;
            end
            default: ctrl_d = IDLE;
        endcase

        // Welcome (and the unused 11 encoding) aborts any lookup; rom_addr is left as is.
        if (in_welcome) begin
            ctrl_d    = IDLE;
            x_d       = X_START;
            y_d       = Y_START;
            steps_d   = '0;
            arrived_d = 1'b0;
            blocked_d = 1'b0;
            busy_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ctrl_q    <= IDLE;
            x_q       <= X_START;
            y_q       <= Y_START;
            tx_q      <= '0;
            ty_q      <= '0;
            addr_q    <= '0;
            arrived_q <= 1'b0;
            blocked_q <= 1'b0;
            busy_q    <= 1'b0;
            steps_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            x_q       <= x_d;
            y_q       <= y_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            addr_q    <= addr_d;
            arrived_q <= arrived_d;
            blocked_q <= blocked_d;
            busy_q    <= busy_d;
            steps_q   <= steps_d;
        end
    end

    assign rom_addr = addr_q;
    assign player_x = x_q;
    assign player_y = y_q;
    assign arrived  = arrived_q;
    assign blocked  = blocked_q;
    assign busy     = busy_q;
    assign steps    = steps_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: a transaction-level model of the player checked every cycle,
// plus directed scenarios with literal expectations. A second instance uses a 2-bit step count.
module tb_player_move_ctrl;

    localparam int NX = 16;
    localparam int NY = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state = 2'b00;
    logic       mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
    logic [255:0] wall = '0;

    logic [7:0] rom_addr1, rom_addr2;
    logic       rom_wall1 = 1'b0, rom_wall2 = 1'b0;
    logic [3:0] px1, px2, py1, py2;
    logic       arr1, arr2, blk1, blk2, busy1, busy2;
    logic [9:0] steps1;
    logic [1:0] steps2;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    player_move_ctrl dut1 (
        .clk(clk), .rst_sys_n(rst_n), .state(state),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .rom_addr(rom_addr1), .rom_wall(rom_wall1), .player_x(px1), .player_y(py1),
        .arrived(arr1), .blocked(blk1), .busy(busy1), .steps(steps1)
    );

    player_move_ctrl #(.STEP_W(2)) dut2 (
        .clk(clk), .rst_sys_n(rst_n), .state(state),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .rom_addr(rom_addr2), .rom_wall(rom_wall2), .player_x(px2), .player_y(py2),
        .arrived(arr2), .blocked(blk2), .busy(busy2), .steps(steps2)
    );

    always @(posedge clk) begin
        rom_wall1 <= wall[rom_addr1];
        rom_wall2 <= wall[rom_addr2];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: player position and counters, plus a lookup that resolves three cycles after it is accepted.
    int m_x, m_y, m_steps, m_steps2, m_addr, m_tx, m_ty, m_pend;
    bit m_arr, m_blk, m_busy;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_steps = 0; m_steps2 = 0; m_addr = 0;
        m_arr = 0; m_blk = 0; m_busy = 0; m_pend = 0;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (state == 2'b00 || state == 2'b11) begin
            m_x = 0; m_y = 0; m_steps = 0; m_steps2 = 0;
            m_arr = 0; m_blk = 0; m_busy = 0; m_pend = 0;
        end else begin
            m_blk = 0;
            if (m_pend == 1) begin
                if (!wall[m_ty * NX + m_tx]) begin
                    m_x = m_tx;
                    m_y = m_ty;
                    m_steps  = (m_steps  < 1023) ? m_steps + 1  : 1023;
                    m_steps2 = (m_steps2 < 3)    ? m_steps2 + 1 : 3;
                    if (m_x == 15 && m_y == 15) m_arr = 1;
                end else begin
                    m_blk = 1;
                end
                m_busy = 0;
                m_pend = 0;
            end else if (m_pend == 2) begin
                m_pend = 1;
            end else if (state == 2'b01 && $countones({mv_up, mv_down, mv_left, mv_right}) == 1) begin
                int tx, ty;
                tx = m_x + (mv_right ? 1 : 0) - (mv_left ? 1 : 0);
                ty = m_y + (mv_down ? 1 : 0) - (mv_up ? 1 : 0);
                if (tx < 0 || tx >= NX || ty < 0 || ty >= NY) begin
                    m_blk = 1;
                end else begin
                    m_tx = tx; m_ty = ty;
                    m_addr = ty * NX + tx;
                    m_busy = 1;
                    m_pend = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("x", int'(px1), m_x);
            chk("y", int'(py1), m_y);
            chk("rom_addr", int'(rom_addr1), m_addr);
            chk("arrived", int'(arr1), int'(m_arr));
            chk("blocked", int'(blk1), int'(m_blk));
            chk("busy", int'(busy1), int'(m_busy));
            chk("steps", int'(steps1), m_steps);
            chk("x_w2", int'(px2), m_x);
            chk("y_w2", int'(py2), m_y);
            chk("busy_w2", int'(busy2), int'(m_busy));
            chk("blocked_w2", int'(blk2), int'(m_blk));
            chk("steps_w2", int'(steps2), m_steps2);
        end
    end

    // Drives a request at a negedge (cycle N); returns in cycle N+1.
    task automatic pulse(input logic [3:0] dir);
        @(negedge clk);
        {mv_up, mv_down, mv_left, mv_right} = dir;
        @(negedge clk);
        {mv_up, mv_down, mv_left, mv_right} = 4'b0000;
    endtask

    // Returns in cycle N+3, where the next request may be issued.
    task automatic do_move(input logic [3:0] dir);
        pulse(dir);
        repeat (2) @(negedge clk);
    endtask

    task automatic welcome_blip();
        @(negedge clk);
        state = 2'b00;
        @(negedge clk);
        state = 2'b01;
    endtask

    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010, RT = 4'b0001;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_x", int'(px1), 0);
        chk("rst_addr", int'(rom_addr1), 0);
        chk("rst_steps", int'(steps1), 0);
        chk("rst_busy", int'(busy1), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        state = 2'b01;

        // Free cell move
        repeat (6) @(negedge clk);
        pulse(RT);
        chk("free_addr", int'(rom_addr1), 8'h01);
        chk("free_busy", int'(busy1), 1);
        repeat (2) @(negedge clk);
        chk("free_x", int'(px1), 1);
        chk("free_y", int'(py1), 0);
        chk("free_steps", int'(steps1), 1);

        // Asynchronous reset during DECIDE
        pulse(RT);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_x", int'(px1), 0);
        chk("arst_steps", int'(steps1), 0);
        chk("arst_busy", int'(busy1), 0);
        chk("arst_addr", int'(rom_addr1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wall at (0,1)
        wall[1 * NX + 0] = 1'b1;
        pulse(DN);
        @(negedge clk);
        chk("wall_blk_n2", int'(blk1), 0);
        @(negedge clk);
        chk("wall_blk_n3", int'(blk1), 1);
        chk("wall_y", int'(py1), 0);
        chk("wall_steps", int'(steps1), 0);
        @(negedge clk);
        chk("wall_blk_n4", int'(blk1), 0);
        wall = '0;

        // Bounds and multi-key
        pulse(LF);
        chk("oob_blk", int'(blk1), 1);
        chk("oob_busy", int'(busy1), 0);
        @(negedge clk);
        chk("oob_blk_n2", int'(blk1), 0);
        pulse(UP | RT);
        chk("multi_blk", int'(blk1), 0);
        chk("multi_busy", int'(busy1), 0);
        repeat (3) @(negedge clk);

        // Abort during WAIT
        pulse(RT);
        state = 2'b00;
        @(negedge clk);
        chk("abort_busy", int'(busy1), 0);
        chk("abort_x", int'(px1), 0);
        state = 2'b01;
        repeat (3) @(negedge clk);
        chk("abort_nocommit", int'(px1), 0);

        // Walk to (14,15); the 2-bit counter saturates on the way
        welcome_blip();
        for (int k = 1; k <= 14; k++) begin
            do_move(RT);
            if (k <= 5) chk("sat_steps2", int'(steps2), (k < 3) ? k : 3);
        end
        for (int k = 1; k <= 15; k++) do_move(DN);
        chk("walk_x", int'(px1), 14);
        chk("walk_y", int'(py1), 15);
        chk("walk_steps", int'(steps1), 29);

        // Two back-to-back requests: the second arrives while busy and is dropped
        @(negedge clk);
        mv_right = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mv_right = 1'b0;
        @(negedge clk);
        chk("exit_x", int'(px1), 15);
        chk("exit_arrived", int'(arr1), 1);
        chk("exit_steps", int'(steps1), 30);
        repeat (4) @(negedge clk);
        chk("exit_steps_hold", int'(steps1), 30);

        // Win state ignores new moves; arrived holds
        state = 2'b10;
        do_move(LF);
        @(negedge clk);
        chk("win_x", int'(px1), 15);
        chk("win_arrived", int'(arr1), 1);
        state = 2'b11;
        @(negedge clk);
        chk("welcome_arrived", int'(arr1), 0);
        chk("welcome_x", int'(px1), 0);
        state = 2'b01;
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
